// File: rtl/buzzer_arbiter_pkg.sv
// Shared definitions for the buzzer arbiter slice.
// Contents: source index constants, FSM state encodings, default timing
// values at 100 MHz, and a helper that turns a cycle count into a
// down-counter load value.
package buzzer_arbiter_pkg;

  // Source indices (bit positions in req/player_* vectors)
  localparam int unsigned SRC_OPEN  = 0;
  localparam int unsigned SRC_CLOSE = 1;
  localparam int unsigned SRC_ALARM = 2;
  localparam int unsigned SRC_KEY   = 3;

  // Default timing at 100 MHz: 100 ms silent gap, 10 s play limit
  localparam int unsigned DEF_GAP_CYCLES     = 10_000_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1_000_000_000;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_PLAY  = 3'd2;
  localparam logic [2:0] ST_CLEAR = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // A phase lasting 'cycles' clocks counts down from cycles-1 to 0.
  function automatic logic [31:0] load_val(input int unsigned cycles);
    return 32'(cycles - 1);
  endfunction

endpackage

// File: rtl/buzzer_arbiter_prio_pick.sv
// Lowest-index-first priority picker.
// Ports:
//   vec   in  N   request vector
//   valid out 1   any bit of vec set
//   idx   out IW  index of the lowest set bit (0 when vec is empty)
module buzzer_arbiter_prio_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set index is written last.
  always_comb begin
    valid = |vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/buzzer_arbiter.sv
// Buzzer arbiter: shares one piezo pin between N_SRC melody players.
// Requests are latched into 'pending'; the lowest pending index is granted,
// its player is started, its melody is routed to the buzzer until it reports
// done (or the play timer expires), it is cleared, and a silent gap follows
// before the next grant. Grants are non-preemptive.
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   req            in   [N_SRC] one-cycle play requests
//   player_done    in   [N_SRC] player finished (level)
//   player_melody  in   [N_SRC] player square-wave outputs
//   player_start   out  [N_SRC] one-cycle start pulse to granted player
//   player_clr     out  [N_SRC] one-cycle clear pulse to granted player
//   buzzer         out  registered buzzer drive
//   busy           out  high whenever the FSM is not idle
//   active_id      out  index of current/last granted source
//   pending        out  [N_SRC] latched, not-yet-served requests
//   timeout_err    out  one-cycle pulse when a play is aborted by timeout
module buzzer_arbiter
  import buzzer_arbiter_pkg::*;
#(
  parameter int unsigned N_SRC          = 4,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_SRC-1:0]         req,
  input  logic [N_SRC-1:0]         player_done,
  input  logic [N_SRC-1:0]         player_melody,
  output logic [N_SRC-1:0]         player_start,
  output logic [N_SRC-1:0]         player_clr,
  output logic                     buzzer,
  output logic                     busy,
  output logic [$clog2(N_SRC)-1:0] active_id,
  output logic [N_SRC-1:0]         pending,
  output logic                     timeout_err
);

  localparam int unsigned ID_W = $clog2(N_SRC);

  logic [2:0]       state;
  logic [31:0]      timer;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_idx;
  logic [N_SRC-1:0] grant_mask;
  logic             sel_done;
  logic             sel_melody;

  buzzer_arbiter_prio_pick #(
    .N  (N_SRC),
    .IW (ID_W)
  ) u_pick (
    .vec   (pending),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Only the granted player's done/melody are ever looked at.
  assign sel_done   = player_done[active_id];
  assign sel_melody = player_melody[active_id];

  // Done takes precedence over an expiring timer in the same cycle.
  assign timeout_err = (state == ST_PLAY) && !sel_done && (timer == '0);

  // Grant mask clears the granted bit, beating a same-cycle req on that bit.
  always_comb begin
    grant_mask   = '0;
    player_start = '0;
    player_clr   = '0;
    if (state == ST_IDLE && pick_valid) grant_mask[pick_idx] = 1'b1;
    if (state == ST_START) player_start[active_id] = 1'b1;
    if (state == ST_CLEAR) player_clr[active_id]   = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      active_id <= '0;
      pending   <= '0;
      busy      <= 1'b0;
      buzzer    <= 1'b0;
    end else begin
      pending <= (pending | req) & ~grant_mask;
      buzzer  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            active_id <= pick_idx;
            state     <= ST_START;
            busy      <= 1'b1;
          end
        end
        ST_START: begin
          timer <= load_val(TIMEOUT_CYCLES);
          state <= ST_PLAY;
        end
        ST_PLAY: begin
          buzzer <= sel_melody;
          if (sel_done || timer == '0) begin
            state <= ST_CLEAR;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        ST_CLEAR: begin
          if (GAP_CYCLES == 0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= load_val(GAP_CYCLES);
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (timer == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
